// File: rtl/dm_responder.sv
// dm_responder: word-addressed data-memory slave with a req/ready handshake
// and WAIT programmable wait states between acceptance and response.
// Optional feature macro: DM_BYTE_WRITE_EN adds the `be` port and
// byte-granular stores.
module dm_responder #(
  parameter int NADDR = 7,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [NADDR-1:0] addr,
  input  logic [31:0]      wdata,
`ifdef DM_BYTE_WRITE_EN
  input  logic [3:0]       be,
`endif
  output logic [31:0]      rdata,
  output logic             ready,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               h_we;
  logic [NADDR-1:0]   h_addr;
  logic [31:0]        h_wdata;
  logic [3:0]         h_be;
  logic [31:0]        mem [2**NADDR];

  logic [3:0]         be_in;
  logic               accept;
  logic               c_fire;
  logic               c_we;
  logic [NADDR-1:0]   c_addr;
  logic [31:0]        c_wdata;
  logic [3:0]         c_be;

`ifdef DM_BYTE_WRITE_EN
  assign be_in = be;
`else
  assign be_in = 4'hF;
`endif

  // A request is taken whenever we are not counting wait states.
  assign accept = req && (state != S_WAIT);

  // Commit is the edge that enters RESP. With no wait states that edge is
  // the accepting edge itself, so the live inputs are committed directly and
  // a coincident reset suppresses it. Otherwise the held request commits on
  // the last wait edge, even if reset arrives on that same edge.
  assign c_fire  = (WAIT == 0) ? (accept && !rst)
                               : ((state == S_WAIT) && (cnt == 4'd1));
  assign c_we    = (WAIT == 0) ? we    : h_we;
  assign c_addr  = (WAIT == 0) ? addr  : h_addr;
  assign c_wdata = (WAIT == 0) ? wdata : h_wdata;
  assign c_be    = (WAIT == 0) ? be_in : h_be;

  // Handshake FSM: holding registers, wait counter, registered ready/busy/rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      h_we    <= 1'b0;
      h_addr  <= '0;
      h_wdata <= 32'h0;
      h_be    <= 4'h0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      if (c_fire && !c_we) rdata <= mem[c_addr];
      case (state)
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (req) begin
            h_we    <= we;
            h_addr  <= addr;
            h_wdata <= wdata;
            h_be    <= be_in;
            cnt     <= 4'(WAIT);
            if (WAIT > 0) begin
              state <= S_WAIT;
              ready <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state <= S_RESP;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Memory array: never reset, written only by a committing store.
  always_ff @(posedge clk) begin
    if (c_fire && c_we) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_addr][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: four instances with WAIT = 2, 0, 3, 4, each driven
// by its own directed stimulus, checked every cycle against a transaction
// model (acceptance cycle + arithmetic on WAIT) plus literal expectations.
module tb_dm_responder;

  localparam logic [15:0] WSP = {4'd4, 4'd3, 4'd0, 4'd2};

  logic        clk;
  logic [3:0]  rst, req, we, rdy, bsy;
  logic [6:0]  ad   [4];
  logic [31:0] wd   [4];
  logic [3:0]  be   [4];
  logic [31:0] rdat [4];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dm_responder #(.NADDR(7), .WAIT(int'(WSP[g*4 +: 4]))) u_dut (
      .clk   (clk),
      .rst   (rst[g]),
      .req   (req[g]),
      .we    (we[g]),
      .addr  (ad[g]),
      .wdata (wd[g]),
`ifdef DM_BYTE_WRITE_EN
      .be    (be[g]),
`endif
      .rdata (rdat[g]),
      .ready (rdy[g]),
      .busy  (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  int          acc  [4];
  bit          pend [4];
  bit          p_we [4];
  logic [6:0]  p_ad [4];
  logic [31:0] p_wd [4];
  logic [3:0]  p_be [4];
  logic [31:0] mmem [4][128];
  bit          mkn  [4][128];
  logic [31:0] e_rd [4];
  bit          e_rdk[4];

  initial begin
    for (int g = 0; g < 4; g++) begin
      pend[g] = 0; acc[g] = 0; e_rdk[g] = 0; e_rd[g] = 0;
      for (int a = 0; a < 128; a++) mkn[g][a] = 0;
    end
  end

  // Edge ending cycle `cyc`: accept, commit (at acc+W), then reset.
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      int w;
      bit free;
      w = int'(WSP[g*4 +: 4]);
      free = !pend[g] || (cyc >= acc[g] + w + 1);
      if (!rst[g] && free && req[g]) begin
        acc[g] = cyc; pend[g] = 1;
        p_we[g] = we[g]; p_ad[g] = ad[g]; p_wd[g] = wd[g]; p_be[g] = be[g];
      end
      if (pend[g] && cyc == acc[g] + w) begin
        if (p_we[g]) begin
          for (int i = 0; i < 4; i++)
            if (p_be[g][i]) mmem[g][p_ad[g]][8*i +: 8] = p_wd[g][8*i +: 8];
          if (p_be[g] == 4'hF) mkn[g][p_ad[g]] = 1;
        end else begin
          e_rd[g]  = mmem[g][p_ad[g]];
          e_rdk[g] = mkn[g][p_ad[g]];
        end
      end
      if (rst[g]) begin
        pend[g] = 0; e_rd[g] = 32'h0; e_rdk[g] = 1;
      end
    end
    cyc++;
  end

  // Every cycle: busy in acc+1..acc+W, ready at acc+W+1, rdata when known.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int g = 0; g < 4; g++) begin
        int w;
        bit eb, er;
        w  = int'(WSP[g*4 +: 4]);
        eb = pend[g] && (cyc >= acc[g] + 1) && (cyc <= acc[g] + w);
        er = pend[g] && (cyc == acc[g] + w + 1);
        chk($sformatf("busy lane%0d cyc%0d", g, cyc), {31'b0, bsy[g]}, {31'b0, eb});
        chk($sformatf("ready lane%0d cyc%0d", g, cyc), {31'b0, rdy[g]}, {31'b0, er});
        if (e_rdk[g])
          chk($sformatf("rdata lane%0d cyc%0d", g, cyc), rdat[g], e_rd[g]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int g, input bit r, input bit w, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    req[g] = r; we[g] = w; ad[g] = a; wd[g] = d; be[g] = b;
  endtask

  // One request, waits (bounded) for ready, returns rdata seen with ready.
  task automatic do_req(input int g, input bit w, input logic [6:0] a,
                        input logic [31:0] d, input logic [3:0] b, output logic [31:0] rd);
    int n;
    set_in(g, 1'b1, w, a, d, b);
    tick();
    req[g] = 1'b0;
    n = 0;
    while (!rdy[g] && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("resp_timeout lane%0d", g), {31'b0, rdy[g]}, 32'd1);
    rd = rdat[g];
    tick();
  endtask

  logic [31:0] rd;

  initial begin
    rst = 4'hF; req = 4'hF; we = 4'h0;
    for (int g = 0; g < 4; g++) begin ad[g] = 7'd0; wd[g] = 32'h0; be[g] = 4'hF; end

    // Reset held 2 cycles with req high: nothing may respond.
    tick(); tick();
    rst = 4'h0; req = 4'h0;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_ready lane%0d", g), {31'b0, rdy[g]}, 32'd0);
      chk($sformatf("rst_busy lane%0d", g), {31'b0, bsy[g]}, 32'd0);
      chk($sformatf("rst_rdata lane%0d", g), rdat[g], 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_ready", {28'b0, rdy}, 32'd0);
    end

    // WAIT=2 (lane 0): store then load addr 5.
    set_in(0, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 4'hF);
    tick(); chk("a_c1_busy", {31'b0, bsy[0]}, 32'd1); req[0] = 1'b0;
    tick(); chk("a_c2_busy", {31'b0, bsy[0]}, 32'd1);
    chk("a_c2_ready", {31'b0, rdy[0]}, 32'd0);
    tick(); chk("a_c3_ready", {31'b0, rdy[0]}, 32'd1);
    chk("a_c3_busy", {31'b0, bsy[0]}, 32'd0);
    set_in(0, 1'b1, 1'b0, 7'd5, 32'h0, 4'hF);
    tick(); req[0] = 1'b0;
    tick();
    tick(); chk("a_c6_ready", {31'b0, rdy[0]}, 32'd1);
    chk("a_c6_rdata", rdat[0], 32'hDEADBEEF);
    tick(); tick();
    chk("a_rdata_hold", rdat[0], 32'hDEADBEEF);

    // WAIT=0 (lane 1): preload 1,2,3 then back-to-back loads.
    for (int i = 1; i <= 3; i++) do_req(1, 1'b1, 7'(i), 32'(i), 4'hF, rd);
    for (int i = 1; i <= 3; i++) begin
      set_in(1, 1'b1, 1'b0, 7'(i), 32'h0, 4'hF);
      tick();
      chk($sformatf("b_ready%0d", i), {31'b0, rdy[1]}, 32'd1);
      chk($sformatf("b_rdata%0d", i), rdat[1], 32'(i));
      chk($sformatf("b_busy%0d", i), {31'b0, bsy[1]}, 32'd0);
    end
    req[1] = 1'b0;
    tick();

    // WAIT=3 (lane 2): second req in cycle 2 is ignored.
    do_req(2, 1'b1, 7'd21, 32'h21, 4'hF, rd);
    set_in(2, 1'b1, 1'b1, 7'd20, 32'h00C0FFEE, 4'hF);
    tick(); chk("c_c1_busy", {31'b0, bsy[2]}, 32'd1); req[2] = 1'b0;
    tick(); set_in(2, 1'b1, 1'b1, 7'd21, 32'h00000BAD, 4'hF);
    tick(); chk("c_c3_ready", {31'b0, rdy[2]}, 32'd0); req[2] = 1'b0;
    tick(); chk("c_c4_ready", {31'b0, rdy[2]}, 32'd1);
    for (int k = 5; k <= 8; k++) begin
      tick();
      chk($sformatf("c_c%0d_ready", k), {31'b0, rdy[2]}, 32'd0);
    end
    do_req(2, 1'b0, 7'd21, 32'h0, 4'hF, rd); chk("c_ign_load21", rd, 32'h21);
    do_req(2, 1'b0, 7'd20, 32'h0, 4'hF, rd); chk("c_load20", rd, 32'h00C0FFEE);

    // WAIT=4 (lane 3): reset in cycle 2 drops the pending store.
    do_req(3, 1'b1, 7'd9, 32'h0, 4'hF, rd);
    set_in(3, 1'b1, 1'b1, 7'd9, 32'h12345678, 4'hF);
    tick(); req[3] = 1'b0;
    tick(); rst[3] = 1'b1;
    tick(); rst[3] = 1'b0;
    chk("d_c3_busy", {31'b0, bsy[3]}, 32'd0);
    for (int k = 3; k <= 8; k++) begin
      chk($sformatf("d_c%0d_ready", k), {31'b0, rdy[3]}, 32'd0);
      tick();
    end
    do_req(3, 1'b0, 7'd9, 32'h0, 4'hF, rd); chk("d_load9", rd, 32'h0);

`ifdef DM_BYTE_WRITE_EN
    // Byte enables (lane 0): partial store and an all-zero enable.
    do_req(0, 1'b1, 7'd7, 32'hAABBCCDD, 4'hF, rd);
    do_req(0, 1'b1, 7'd7, 32'h11223344, 4'b0101, rd);
    do_req(0, 1'b0, 7'd7, 32'h0, 4'b0000, rd); chk("e_be0101", rd, 32'hAA22CC44);
    do_req(0, 1'b1, 7'd7, 32'hFFFFFFFF, 4'b0000, rd);
    do_req(0, 1'b0, 7'd7, 32'h0, 4'hF, rd); chk("e_be0000", rd, 32'hAA22CC44);
`endif

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Word-addressed data-memory responder that services load/store requests from the CPU's MEM stage through a request/ready handshake with a programmable number of wait states. It replaces the zero-latency data memory with a slave that models slow memory. Stall generation belongs to the pipeline: the CPU holds stage 4 until `ready` is asserted.

## Interface

Parameters:
- `NADDR`, default 7: word-address width; memory depth is 2^NADDR 32-bit words.
- `WAIT`, default 2: wait states inserted between request acceptance and response; legal range 0..15.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 1: request strobe, sampled on the rising edge.
- `we`, input, 1: 1 = store, 0 = load; qualified by `req`.
- `addr`, input, NADDR: word address; this is CPU byte address bits [NADDR+1:2].
- `wdata`, input, 32: store data; qualified by `req & we`.
- `be`, input, 4: byte enables; present only with `DM_BYTE_WRITE_EN`. Bit i enables `wdata[8i+7:8i]`.
- `rdata`, output, 32: load data, registered; valid while `ready` is high after a load.
- `ready`, output, 1: one-cycle response pulse marking completion of the accepted request.
- `busy`, output, 1: high while a request is accepted and its response has not yet been given (WAIT state).

## Operation

- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - `req` = 1 at an edge latches `we`, `addr`, `wdata` (and `be`) into holding registers.
  - The wait counter loads `WAIT`.
  - Next state is WAIT if `WAIT` > 0, otherwise RESP.
- **WAIT**
  - The counter decrements each edge.
  - When the counter equals 1 at an edge, the request commits and the next state is RESP.
  - `req` is ignored in WAIT; no queueing.
- **Commit** happens on the edge entering RESP.
  - Store: the memory word is written.
  - Load: `rdata` is loaded from the memory word.
- **RESP**
  - `ready` = 1 for exactly this cycle.
  - `req` = 1 at the edge leaving RESP is accepted exactly as in IDLE (back-to-back requests).
  - Otherwise the next state is IDLE.
- A store response leaves `rdata` unchanged. `rdata` holds the last load value indefinitely.
- A store followed by a load to the same address returns the stored data, because the store commits before the load is accepted.
- `busy` = (state == WAIT). `ready` = (state == RESP).
- Memory contents are uninitialised at start. They are not cleared by `rst`.

## Timing

- Reset values: state IDLE, `ready` 0, `busy` 0, `rdata` 32'h0, counter 0, holding registers 0.
- Latency: `req` high in cycle n gives `ready` high in cycle n+WAIT+1.
- `busy` is high in cycles n+1 .. n+WAIT (never high when WAIT = 0).
- Throughput: one request per WAIT+1 cycles when `req` is held high continuously.
- Reset mid-operation: `rst` at any edge forces IDLE.
  - An uncommitted store is dropped and the memory is unchanged.
  - A store that committed on the same edge as `rst` is retained.
  - `req` coincident with `rst` is ignored.
- Address wrap: not applicable, since `addr` exactly spans the memory.

## Configuration

- Macro: `DM_BYTE_WRITE_EN`.
- Defined:
  - The `be` port exists.
  - A store writes only the enabled bytes; the other bytes keep their old value.
  - `be` = 4'b0000 completes the handshake normally with no memory change.
  - Loads ignore `be` and always return the full word.
- Undefined: the `be` port is absent and every store writes all 32 bits.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `req` = 1 -> `ready` = 0, `busy` = 0, `rdata` = 0, and no response afterward.
- **WAIT=2 store then load:** store 32'hDEADBEEF to addr 5 in cycle 0 -> `busy` high in cycles 1–2, `ready` in cycle 3. Load addr 5 in cycle 3 -> `ready` in cycle 6 with `rdata` = 32'hDEADBEEF.
- **WAIT=0 back-to-back:** `req` held high for loads to addr 1, 2, 3 (preloaded 1, 2, 3) -> `ready` high in cycles 1, 2, 3 with `rdata` = 1, 2, 3; `busy` never high.
- **Ignored request:** WAIT=3, second `req` in cycle 2 while busy -> exactly one `ready` pulse (cycle 4); the second request has no effect.
- **Reset mid-store:** WAIT=4, store 32'h12345678 to addr 9 (old value 32'h0), `rst` in cycle 2 -> no `ready`; a later load of addr 9 returns 32'h0.
- **Byte enables (`DM_BYTE_WRITE_EN`):** addr 7 = 32'hAABBCCDD; store 32'h11223344 with `be` = 4'b0101 -> a load of addr 7 returns 32'hAA22CC44.
